// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the hazard scheduler: tuse/tnew encoding, mult/div latencies
// and the mult/div busy state type.
package hazard_stall_ctrl_pkg;

  localparam int TW          = 3;
  localparam int MD_CNT_W    = 4;
  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  localparam logic [TW-1:0] TUSE_NONE = 3'd7;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // A producer in flight blocks the consumer when its result arrives later than it is needed.
  function automatic logic src_hazard(
    input logic [4:0]    src,
    input logic [TW-1:0] tuse,
    input logic [4:0]    a3,
    input logic [TW-1:0] tnew,
    input logic          we
  );
    return we && (a3 == src) && (tuse < tnew);
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_md_busy_counter.sv
// Mult/div busy countdown: loads the unit latency on a start pulse, then counts to zero.
// A start while busy reloads the counter.
module md_busy_counter
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES_P = MULT_CYCLES,
  parameter int DIV_CYCLES_P  = DIV_CYCLES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_start,
  input  logic                i_is_div,
  output logic [MD_CNT_W-1:0] o_cnt,
  output logic                o_busy,
  output md_state_e           o_state
);

  logic [MD_CNT_W-1:0] r_cnt;
  md_state_e           r_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_state <= MD_IDLE;
    end else if (i_start) begin
      r_cnt   <= i_is_div ? MD_CNT_W'(DIV_CYCLES_P) : MD_CNT_W'(MULT_CYCLES_P);
      r_state <= MD_BUSY;
    end else if (r_cnt != '0) begin
      r_cnt   <= r_cnt - MD_CNT_W'(1);
      r_state <= (r_cnt > MD_CNT_W'(1)) ? MD_BUSY : MD_IDLE;
    end
  end

  assign o_cnt   = r_cnt;
  assign o_state = r_state;
  assign o_busy  = (r_state == MD_BUSY);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// D-stage issue scheduler: stalls on unresolved register producers in E/M and on a busy
// mult/div unit, and counts stalled cycles.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES_P = MULT_CYCLES,
  parameter int DIV_CYCLES_P  = DIV_CYCLES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [4:0]          rs_d,
  input  logic [4:0]          rt_d,
  input  logic [TW-1:0]       tuse_rs_d,
  input  logic [TW-1:0]       tuse_rt_d,
  input  logic                md_use_d,
  input  logic [4:0]          a3_e,
  input  logic [TW-1:0]       tnew_e,
  input  logic                regwrite_e,
  input  logic [4:0]          a3_m,
  input  logic [TW-1:0]       tnew_m,
  input  logic                regwrite_m,
  input  logic                md_start_e,
  input  logic                md_is_div_e,
  output logic                stall,
  output logic                md_busy,
  output logic [MD_CNT_W-1:0] md_cnt,
  output logic [31:0]         stall_cnt
);

  logic      w_hz_rs;
  logic      w_hz_rt;
  logic      w_hz_md;
  md_state_e w_md_state;
  logic [31:0] r_stall_cnt;

  md_busy_counter #(
    .MULT_CYCLES_P (MULT_CYCLES_P),
    .DIV_CYCLES_P  (DIV_CYCLES_P)
  ) u_md_busy_counter (
    .clk      (clk),
    .reset    (reset),
    .i_start  (md_start_e),
    .i_is_div (md_is_div_e),
    .o_cnt    (md_cnt),
    .o_busy   (md_busy),
    .o_state  (w_md_state)
  );

  // $0 is hardwired, so it never waits on a producer.
  assign w_hz_rs = (tuse_rs_d != TUSE_NONE) && (rs_d != 5'd0) &&
                   (src_hazard(rs_d, tuse_rs_d, a3_e, tnew_e, regwrite_e) ||
                    src_hazard(rs_d, tuse_rs_d, a3_m, tnew_m, regwrite_m));

  assign w_hz_rt = (tuse_rt_d != TUSE_NONE) && (rt_d != 5'd0) &&
                   (src_hazard(rt_d, tuse_rt_d, a3_e, tnew_e, regwrite_e) ||
                    src_hazard(rt_d, tuse_rt_d, a3_m, tnew_m, regwrite_m));

  // The start pulse counts as busy so an MD consumer right behind its producer waits.
  assign w_hz_md = md_use_d && (md_start_e || (w_md_state == MD_BUSY));

  assign stall = !reset && (w_hz_rs || w_hz_rt || w_hz_md);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (stall) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule
